// File: rtl/rv32_pkg.sv
// +--------------------------------------------------------------------+
// | rv32_pkg: shared fetch-sequencer types and constants. Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

package rv32_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    EXEC     = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;
  localparam int          PC_STEP       = 4;

endpackage

`default_nettype wire

// File: rtl/next_pc_sel.sv
// +--------------------------------------------------------------------+
// | next_pc_sel: next-PC mux and alignment check (combinational). 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module next_pc_sel
  import rv32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_imm_ext,
  input  logic [WIDTH-1:0] i_rs1_val,
  input  logic             i_jalr,
  input  logic             i_jump,
  input  logic             i_br_taken,
  output logic [WIDTH-1:0] o_next_pc,
  output logic             o_misaligned
);

  logic [WIDTH-1:0] w_next_pc;

  always_comb begin
    w_next_pc = i_pc + WIDTH'(PC_STEP);
    if (i_jalr) begin
      w_next_pc = (i_rs1_val + i_imm_ext) & ~WIDTH'(1);
    end else if (i_jump || i_br_taken) begin
      w_next_pc = i_pc + i_imm_ext;
    end
  end

  assign o_next_pc    = w_next_pc;
  assign o_misaligned = |w_next_pc[1:0];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +--------------------------------------------------------------------+
// | pc_sequencer: RV32I fetch / next-PC controller with trap. Rev 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
  import rv32_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(TRAP_VEC_DEF),
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NOP_INSTR_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc,
  input  logic             retire,
  input  logic             br_taken,
  input  logic             jump,
  input  logic             jalr,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [WIDTH-1:0] rs1_val,
  output logic             trap,
  output logic [WIDTH-1:0] trap_pc,
  output logic [WIDTH-1:0] instret
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic             r_instr_valid;
  logic             r_trap;
  logic [WIDTH-1:0] r_trap_pc;
  logic [WIDTH-1:0] r_instret;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_misaligned;

  next_pc_sel #(.WIDTH(WIDTH)) u_next_pc_sel (
    .i_pc        (r_pc),
    .i_imm_ext   (imm_ext),
    .i_rs1_val   (rs1_val),
    .i_jalr      (jalr),
    .i_jump      (jump),
    .i_br_taken  (br_taken),
    .o_next_pc   (w_next_pc),
    .o_misaligned(w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_pc          <= RESET_VEC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_trap        <= 1'b0;
      r_trap_pc     <= '0;
      r_instret     <= '0;
    end else begin
      r_trap <= 1'b0;
      case (r_state)
        FETCH: begin
          if (imem_req_ready) r_state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (imem_rsp_valid) begin
            r_instr       <= imem_rsp_data;
            r_instr_valid <= 1'b1;
            r_state       <= EXEC;
          end
        end
        EXEC: begin
          if (retire) begin
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_state       <= FETCH;
            // A misaligned target redirects to the trap vector without retiring.
            if (w_misaligned) begin
              r_pc      <= TRAP_VEC;
              r_trap    <= 1'b1;
              r_trap_pc <= r_pc;
            end else begin
              r_pc      <= w_next_pc;
              r_instret <= r_instret + WIDTH'(1);
            end
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign imem_req_valid = (r_state == FETCH);
  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign trap           = r_trap;
  assign trap_pc        = r_trap_pc;
  assign instret        = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_pc_sequencer: randomized self-checking bench for pc_sequencer.   |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TVEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr, pc;
  logic        retire, br_taken, jump, jalr;
  logic [31:0] imm_ext, rs1_val;
  logic        trap;
  logic [31:0] trap_pc, instret;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_instret, m_trap_pc;
  bit          m_trap;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .retire(retire), .br_taken(br_taken),
    .jump(jump), .jalr(jalr), .imm_ext(imm_ext), .rs1_val(rs1_val),
    .trap(trap), .trap_pc(trap_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  // Reference: architectural effect of one retire, straight from the ISA rules.
  task automatic model_retire(input bit br, input bit jp, input bit jr,
                              input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] tgt;
    if (jr)           tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (jp | br) tgt = m_pc + imm;
    else              tgt = m_pc + 32'd4;
    if (tgt % 4 != 0) begin
      m_trap_pc = m_pc;
      m_pc      = TVEC;
      m_trap    = 1'b1;
    end else begin
      m_pc      = tgt;
      m_instret = m_instret + 32'd1;
      m_trap    = 1'b0;
    end
  endtask

  // Drives one full fetch/execute/retire handshake; observations are returned.
  task automatic run_instr(input int rw, input int sw, input int tw,
                           input bit br, input bit jp, input bit jr,
                           input logic [31:0] imm, input logic [31:0] rs1,
                           input logic [31:0] dat,
                           output logic [31:0] addr, output bit hold_ok,
                           output bit nop_ok, output logic [31:0] instr_seen,
                           output bit trap1, output bit trap2, output bit tmo);
    int k;
    hold_ok = 1; nop_ok = 1; tmo = 0; k = 0;
    while (imem_req_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (imem_req_valid !== 1'b1) tmo = 1;
    addr = imem_addr;
    if (instr_valid !== 1'b0 || instr !== NOP) nop_ok = 0;
    repeat (rw) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'($urandom);
      @(negedge clk);
      if (imem_req_valid !== 1'b1 || imem_addr !== addr) hold_ok = 0;
      if (instr_valid !== 1'b0 || instr !== NOP) nop_ok = 0;
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    if (imem_req_valid !== 1'b0) hold_ok = 0;
    repeat (sw) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b0) hold_ok = 0;
      if (instr_valid !== 1'b0 || instr !== NOP) nop_ok = 0;
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = dat;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    instr_seen = (instr_valid === 1'b1) ? instr : 32'hxxxx_xxxx;
    repeat (tw) begin
      @(negedge clk);
      if (instr !== dat || instr_valid !== 1'b1 || imem_req_valid !== 1'b0) hold_ok = 0;
    end
    retire = 1'b1; br_taken = br; jump = jp; jalr = jr; imm_ext = imm; rs1_val = rs1;
    @(negedge clk);
    retire = 1'b0; br_taken = 1'b0; jump = 1'b0; jalr = 1'b0;
    imm_ext = $urandom; rs1_val = $urandom;
    trap1 = trap;
    if (instr_valid !== 1'b0 || instr !== NOP) nop_ok = 0;
    @(negedge clk);
    trap2 = trap;
  endtask

  task automatic test_instr(input string nm, input int rw, input int sw, input int tw,
                            input bit br, input bit jp, input bit jr,
                            input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] a, iseen, dat;
    bit hold_ok, nop_ok, t1, t2, tmo;
    dat = $urandom;
    run_instr(rw, sw, tw, br, jp, jr, imm, rs1, dat, a, hold_ok, nop_ok, iseen, t1, t2, tmo);
    n_checks++;
    if (tmo || a !== m_pc) begin
      n_fail++;
      $display("FAIL %s fetch_addr: got %h (timeout=%0d) expected %h", nm, a, tmo, m_pc);
    end
    n_checks++;
    if (!hold_ok || !nop_ok) begin
      n_fail++;
      $display("FAIL %s handshake: hold_ok=%0d nop_ok=%0d expected 1 1", nm, hold_ok, nop_ok);
    end
    n_checks++;
    if (iseen !== dat) begin
      n_fail++;
      $display("FAIL %s instr_latch: got %h expected %h", nm, iseen, dat);
    end
    model_retire(br, jp, jr, imm, rs1);
    n_checks++;
    if (t1 !== m_trap || t2 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s trap_pulse: got %0d,%0d expected %0d,0", nm, t1, t2, m_trap);
    end
    n_checks++;
    if (pc !== m_pc || imem_addr !== m_pc) begin
      n_fail++;
      $display("FAIL %s next_pc: got pc=%h addr=%h expected %h", nm, pc, imem_addr, m_pc);
    end
    n_checks++;
    if (instret !== m_instret || trap_pc !== m_trap_pc) begin
      n_fail++;
      $display("FAIL %s counters: got instret=%h trap_pc=%h expected %h %h",
               nm, instret, trap_pc, m_instret, m_trap_pc);
    end
  endtask

  task automatic goto_pc(input logic [31:0] tgt);
    test_instr("goto", 0, 0, 0, 0, 1, 0, tgt - m_pc, 32'h0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    m_pc = 32'h0; m_instret = 32'h0; m_trap_pc = 32'h0; m_trap = 1'b0;
    n_checks++;
    if (pc !== 32'h0 || instr !== NOP || instr_valid !== 1'b0 || trap !== 1'b0 ||
        trap_pc !== 32'h0 || instret !== 32'h0 || imem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h instr=%h iv=%0d trap=%0d tpc=%h ir=%h rv=%0d expected 0 13 0 0 0 0 1",
               pc, instr, instr_valid, trap, trap_pc, instret, imem_req_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) test_instr("seq", 0, 0, 0, 0, 0, 0, $urandom, $urandom);
    n_checks++;
    if (instret !== 32'd3 || pc !== 32'hC) begin
      n_fail++;
      $display("FAIL seq_count: got instret=%0d pc=%h expected 3 0000000c", instret, pc);
    end
  endtask

  task automatic test_req_stall;
    goto_pc(32'h10);
    test_instr("req_stall", 4, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    test_instr("all_waits", 2, 3, 2, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_branch;
    goto_pc(32'h20);
    test_instr("branch", 0, 1, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h0);
    n_checks++;
    if (pc !== 32'h10) begin
      n_fail++;
      $display("FAIL branch_target: got %h expected 00000010", pc);
    end
  endtask

  task automatic test_jalr;
    test_instr("jalr", 0, 0, 1, 1, 0, 1, 32'h3, 32'h1001);
    n_checks++;
    if (pc !== 32'h1004) begin
      n_fail++;
      $display("FAIL jalr_target: got %h expected 00001004", pc);
    end
  endtask

  task automatic test_trap;
    logic [31:0] ir_before;
    goto_pc(32'h40);
    ir_before = m_instret;
    test_instr("jal_trap", 0, 0, 0, 0, 1, 0, 32'h6, 32'h0);
    n_checks++;
    if (pc !== TVEC || trap_pc !== 32'h40 || instret !== ir_before) begin
      n_fail++;
      $display("FAIL trap_result: got pc=%h trap_pc=%h instret=%h expected 00000100 00000040 %h",
               pc, trap_pc, instret, ir_before);
    end
  endtask

  task automatic test_wrap;
    goto_pc(32'hFFFF_FFFC);
    test_instr("pc_wrap", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] imm;
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
      test_instr("random", $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), imm, $urandom);
    end
  endtask

  task automatic test_reset_midflight;
    int k;
    k = 0;
    while (imem_req_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    m_pc = 32'h0; m_instret = 32'h0; m_trap_pc = 32'h0; m_trap = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== NOP || imem_req_valid !== 1'b1 ||
        imem_addr !== 32'h0 || instret !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_midflight: got iv=%0d instr=%h rv=%0d addr=%h ir=%h expected 0 13 1 0 0",
               instr_valid, instr, imem_req_valid, imem_addr, instret);
    end
    test_instr("after_rst", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    retire = 1'b0; br_taken = 1'b0; jump = 1'b0; jalr = 1'b0;
    imm_ext = 32'h0; rs1_val = 32'h0;
    repeat (2) @(negedge clk);
    test_reset;
    test_sequential;
    test_req_stall;
    test_branch;
    test_jalr;
    test_trap;
    test_wrap;
    test_random;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
